eth_tx_sched: RTL and testbench

Transmit frame scheduler for the Ethernet TX path. Two frame sources each offer a length descriptor and a byte FIFO. The block picks one source by round-robin and runs the four-phase `word_count`/`word_count_ready`/`word_count_ack` handshake toward the GMII transmitter. While that frame is on the wire it steers the transmitter's FIFO read port to the chosen source, then enforces a minimum inter-frame gap before it grants again.

---
 rtl/eth_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_eth_tx_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - two-source round-robin TX frame scheduler with IPG enforcement
// Optional TX_SCHED_STATS_EN adds per-source 16-bit completed-frame counters.
module eth_tx_sched #(
   parameter int IPG_CYCLES = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [10:0] req0_len,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [10:0] req1_len,
   output logic        req1_ready,
   input  logic [7:0]  src0_fifo_data,
   input  logic        src0_fifo_empty,
   output logic        src0_fifo_rd,
   input  logic [7:0]  src1_fifo_data,
   input  logic        src1_fifo_empty,
   output logic        src1_fifo_rd,
   output logic [7:0]  fifo_data,
   output logic        fifo_empty,
   input  logic        fifo_rd,
   output logic [10:0] word_count,
   output logic        word_count_ready,
   input  logic        word_count_ack
`ifdef TX_SCHED_STATS_EN
   ,
   output logic [15:0] frames0,
   output logic [15:0] frames1
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_XFER, S_GAP} state_t;

   localparam logic [7:0] GAP_LOAD = 8'(IPG_CYCLES - 1);

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic        last_q, last_d;
   logic        req0_ready_q, req0_ready_d;
   logic        req1_ready_q, req1_ready_d;
   logic [10:0] word_count_q, word_count_d;
   logic        wcr_q, wcr_d;
   logic [11:0] rd_cnt_q, rd_cnt_d;
   logic [7:0]  gap_q, gap_d;
   logic        active;
   logic        grant1;
`ifdef TX_SCHED_STATS_EN
   logic [15:0] frames0_q, frames0_d;
   logic [15:0] frames1_q, frames1_d;
`endif

   // The read port is only open while a granted frame owns the transmitter.
   assign active = (state_q == S_REQ) || (state_q == S_REL) || (state_q == S_XFER);

   assign fifo_data    = sel_q ? src1_fifo_data : src0_fifo_data;
   assign fifo_empty   = active ? (sel_q ? src1_fifo_empty : src0_fifo_empty) : 1'b1;
   assign src0_fifo_rd = active && !sel_q && fifo_rd;
   assign src1_fifo_rd = active && sel_q && fifo_rd;

   assign req0_ready       = req0_ready_q;
   assign req1_ready       = req1_ready_q;
   assign word_count       = word_count_q;
   assign word_count_ready = wcr_q;
`ifdef TX_SCHED_STATS_EN
   assign frames0 = frames0_q;
   assign frames1 = frames1_q;
`endif

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      req0_ready_d = 1'b0;
      req1_ready_d = 1'b0;
      word_count_d = word_count_q;
      wcr_d        = wcr_q;
      rd_cnt_d     = rd_cnt_q;
      gap_d        = gap_q;
      grant1       = 1'b0;
`ifdef TX_SCHED_STATS_EN
      frames0_d    = frames0_q;
      frames1_d    = frames1_q;
`endif
      if (active && fifo_rd) begin
         rd_cnt_d = rd_cnt_q + 12'd1;
      end
      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant1       = req1_valid && (!req0_valid || !last_q);
               sel_d        = grant1;
               last_d       = grant1;
               req0_ready_d = !grant1;
               req1_ready_d = grant1;
               word_count_d = grant1 ? req1_len : req0_len;
               rd_cnt_d     = 12'd0;
               state_d      = S_REQ;
            end
         end
         S_REQ: begin
            // Only an ack seen while the request is up completes the handshake.
            if (wcr_q && word_count_ack) begin
               wcr_d   = 1'b0;
               state_d = S_REL;
            end else begin
               wcr_d = 1'b1;
            end
         end
         S_REL: begin
            if (!word_count_ack) begin
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (rd_cnt_q == ({1'b0, word_count_q} + 12'd1)) begin
               state_d = S_GAP;
               gap_d   = GAP_LOAD;
`ifdef TX_SCHED_STATS_EN
               if (sel_q) begin
                  frames1_d = frames1_q + 16'd1;
               end else begin
                  frames0_d = frames0_q + 16'd1;
               end
`endif
            end
         end
         S_GAP: begin
            if (gap_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sel_q        <= 1'b0;
         last_q       <= 1'b1;
         req0_ready_q <= 1'b0;
         req1_ready_q <= 1'b0;
         word_count_q <= 11'd0;
         wcr_q        <= 1'b0;
         rd_cnt_q     <= 12'd0;
         gap_q        <= 8'd0;
`ifdef TX_SCHED_STATS_EN
         frames0_q    <= 16'd0;
         frames1_q    <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         req0_ready_q <= req0_ready_d;
         req1_ready_q <= req1_ready_d;
         word_count_q <= word_count_d;
         wcr_q        <= wcr_d;
         rd_cnt_q     <= rd_cnt_d;
         gap_q        <= gap_d;
`ifdef TX_SCHED_STATS_EN
         frames0_q    <= frames0_d;
         frames1_q    <= frames1_d;
`endif
      end
   end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - directed self-checking bench for eth_tx_sched
module tb_eth_tx_sched;

   localparam int IPG = 12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [10:0] req0_len = 11'd0, req1_len = 11'd0;
   logic        req0_ready, req1_ready;
   logic [7:0]  src0_fifo_data = 8'hA5, src1_fifo_data = 8'h5A;
   logic        src0_fifo_empty = 1'b0, src1_fifo_empty = 1'b0;
   logic        src0_fifo_rd, src1_fifo_rd;
   logic [7:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_rd = 1'b0;
   logic [10:0] word_count;
   logic        word_count_ready;
   logic        word_count_ack = 1'b0;
`ifdef TX_SCHED_STATS_EN
   logic [15:0] frames0, frames1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   eth_tx_sched #(.IPG_CYCLES(IPG)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_len(req0_len), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_len(req1_len), .req1_ready(req1_ready),
      .src0_fifo_data(src0_fifo_data), .src0_fifo_empty(src0_fifo_empty), .src0_fifo_rd(src0_fifo_rd),
      .src1_fifo_data(src1_fifo_data), .src1_fifo_empty(src1_fifo_empty), .src1_fifo_rd(src1_fifo_rd),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
      .word_count(word_count), .word_count_ready(word_count_ready), .word_count_ack(word_count_ack)
`ifdef TX_SCHED_STATS_EN
      , .frames0(frames0), .frames1(frames1)
`endif
   );

   always #5 clk = ~clk;

   task automatic grant_wait(output int who, output int lat);
      who = -1;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            who = req1_ready ? 1 : 0;
            lat = i;
            break;
         end
      end
   endtask

   task automatic handshake(input int delay, output int ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (word_count_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (ok == 1) begin
         repeat (delay) @(negedge clk);
         word_count_ack = 1'b1;
         ok = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!word_count_ready) begin
               ok = 1;
               break;
            end
         end
         word_count_ack = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_reads(input int n, output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < n; i++) begin
         fifo_rd = 1'b1;
         #1;
         if (src0_fifo_rd) c0++;
         if (src1_fifo_rd) c1++;
         @(negedge clk);
      end
      fifo_rd = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fifo_rd = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
      n_cmp++; if ({src0_fifo_rd, src1_fifo_rd} !== 2'b00) begin n_err++; $display("FAIL reset_src_rd: got %b want 00", {src0_fifo_rd, src1_fifo_rd}); end
      n_cmp++; if (word_count !== 11'd0 || word_count_ready !== 1'b0) begin n_err++; $display("FAIL reset_wc: got wc=%0d wcr=%b want 0/0", word_count, word_count_ready); end
      n_cmp++; if (fifo_empty !== 1'b1 || fifo_data !== 8'hA5) begin n_err++; $display("FAIL reset_fifo: got empty=%b data=%h want 1/a5", fifo_empty, fifo_data); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (src0_fifo_rd !== 1'b0 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL idle_stray_rd: got rd=%b empty=%b want 0/1", src0_fifo_rd, fifo_empty); end
      fifo_rd = 1'b0;
   endtask

   task automatic test_single_frame();
      int who, lat, ok, c0, c1;
      req0_len = 11'd3;
      req0_valid = 1'b1;
      grant_wait(who, lat);
      req0_valid = 1'b0;
      n_cmp++; if (who !== 0 || lat !== 1) begin n_err++; $display("FAIL single_grant: got who=%0d lat=%0d want 0/1", who, lat); end
      @(negedge clk);
      n_cmp++; if (req0_ready !== 1'b0 || word_count_ready !== 1'b1) begin n_err++; $display("FAIL single_pulse: got rdy=%b wcr=%b want 0/1", req0_ready, word_count_ready); end
      n_cmp++; if (word_count !== 11'd3) begin n_err++; $display("FAIL single_wc: got %0d want 3", word_count); end
      repeat (2) @(negedge clk);
      word_count_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (word_count_ready !== 1'b0) begin n_err++; $display("FAIL single_wcr_drop: got %b want 0", word_count_ready); end
      word_count_ack = 1'b0;
      @(negedge clk);
      fifo_rd = 1'b1;
      #1;
      n_cmp++; if (src0_fifo_rd !== 1'b1 || fifo_data !== 8'hA5 || fifo_empty !== 1'b0) begin n_err++; $display("FAIL single_steer: got rd=%b data=%h empty=%b want 1/a5/0", src0_fifo_rd, fifo_data, fifo_empty); end
      do_reads(4, c0, c1);
      n_cmp++; if (c0 !== 4 || c1 !== 0) begin n_err++; $display("FAIL single_reads: got c0=%0d c1=%0d want 4/0", c0, c1); end
      req1_len = 11'd0;
      req1_valid = 1'b1;
      grant_wait(who, lat);
      req1_valid = 1'b0;
      n_cmp++; if (who !== 1 || lat !== IPG + 2) begin n_err++; $display("FAIL single_gap: got who=%0d lat=%0d want 1/%0d", who, lat, IPG + 2); end
   endtask

   task automatic test_len0();
      int ok, c0, c1;
      handshake(1, ok);
      n_cmp++; if (ok !== 1 || word_count !== 11'd0) begin n_err++; $display("FAIL len0_hs: got ok=%0d wc=%0d want 1/0", ok, word_count); end
      do_reads(1, c0, c1);
      n_cmp++; if (c0 !== 0 || c1 !== 1) begin n_err++; $display("FAIL len0_reads: got c0=%0d c1=%0d want 0/1", c0, c1); end
      @(negedge clk);
      fifo_rd = 1'b1;
      #1;
      n_cmp++; if ({src0_fifo_rd, src1_fifo_rd} !== 2'b00 || fifo_empty !== 1'b1) begin n_err++; $display("FAIL len0_gap: got rd=%b empty=%b want 00/1", {src0_fifo_rd, src1_fifo_rd}, fifo_empty); end
      fifo_rd = 1'b0;
      repeat (IPG + 4) @(negedge clk);
   endtask

   task automatic test_len2047();
      int who, lat, ok, c0, c1;
      req0_len = 11'd2047;
      req0_valid = 1'b1;
      grant_wait(who, lat);
      req0_valid = 1'b0;
      handshake(0, ok);
      n_cmp++; if (who !== 0 || ok !== 1 || word_count !== 11'd2047) begin n_err++; $display("FAIL max_hs: got who=%0d ok=%0d wc=%0d want 0/1/2047", who, ok, word_count); end
      do_reads(2048, c0, c1);
      n_cmp++; if (c0 !== 2048 || c1 !== 0) begin n_err++; $display("FAIL max_reads: got c0=%0d c1=%0d want 2048/0", c0, c1); end
      n_cmp++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL max_xfer_hold: got empty=%b want 0", fifo_empty); end
      @(negedge clk);
      n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL max_gap: got empty=%b want 1", fifo_empty); end
      repeat (IPG + 4) @(negedge clk);
   endtask

   task automatic test_contention();
      int who, lat, ok, c0, c1;
      int left0, left1;
      logic [5:0] order;
      order = 6'd0;
      left0 = 3;
      left1 = 3;
      req0_len = 11'd1;
      req1_len = 11'd2;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      apply_reset();
      for (int g = 0; g < 6; g++) begin
         grant_wait(who, lat);
         if (who == 0) left0--;
         if (who == 1) left1--;
         order[g] = (who == 1);
         req0_valid = (left0 > 0);
         req1_valid = (left1 > 0);
         handshake(1, ok);
         n_cmp++; if (ok !== 1 || word_count !== (who == 1 ? 11'd2 : 11'd1)) begin n_err++; $display("FAIL rr_wc%0d: got ok=%0d wc=%0d who=%0d", g, ok, word_count, who); end
         do_reads(who == 1 ? 3 : 2, c0, c1);
         n_cmp++; if ((who == 1 ? c1 : c0) !== (who == 1 ? 3 : 2) || (who == 1 ? c0 : c1) !== 0) begin n_err++; $display("FAIL rr_reads%0d: got c0=%0d c1=%0d who=%0d", g, c0, c1, who); end
      end
      n_cmp++; if (order !== 6'b101010) begin n_err++; $display("FAIL rr_order: got %b want 101010", order); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (IPG + 4) @(negedge clk);
   endtask

   task automatic test_stall();
      int who, lat, ok, c0, c1, bad;
      bad = 0;
      req0_len = 11'd5;
      req1_len = 11'd1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      grant_wait(who, lat);
      req0_valid = 1'b0;
      n_cmp++; if (who !== 0) begin n_err++; $display("FAIL stall_grant: got %0d want 0", who); end
      @(negedge clk);
      for (int i = 0; i < 50; i++) begin
         if (word_count_ready !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
      word_count_ack = 1'b1;
      @(negedge clk);
      n_cmp++; if (word_count_ready !== 1'b0) begin n_err++; $display("FAIL stall_drop: got %b want 0", word_count_ready); end
      word_count_ack = 1'b0;
      @(negedge clk);
      do_reads(6, c0, c1);
      n_cmp++; if (c0 !== 6 || c1 !== 0) begin n_err++; $display("FAIL stall_reads: got c0=%0d c1=%0d want 6/0", c0, c1); end
      grant_wait(who, lat);
      req1_valid = 1'b0;
      n_cmp++; if (who !== 1 || lat !== IPG + 2) begin n_err++; $display("FAIL stall_next: got who=%0d lat=%0d want 1/%0d", who, lat, IPG + 2); end
      handshake(0, ok);
      do_reads(2, c0, c1);
      repeat (IPG + 4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int who, lat, ok, c0, c1;
      req1_len = 11'd9;
      req1_valid = 1'b1;
      grant_wait(who, lat);
      req1_valid = 1'b0;
      handshake(0, ok);
      do_reads(5, c0, c1);
      n_cmp++; if (c1 !== 5 || c0 !== 0) begin n_err++; $display("FAIL mid_pre: got c0=%0d c1=%0d want 0/5", c0, c1); end
      fifo_rd = 1'b1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({src0_fifo_rd, src1_fifo_rd, req0_ready, req1_ready, word_count_ready} !== 5'b00000) begin n_err++; $display("FAIL mid_strobes: got %b want 00000", {src0_fifo_rd, src1_fifo_rd, req0_ready, req1_ready, word_count_ready}); end
      n_cmp++; if (word_count !== 11'd0 || fifo_empty !== 1'b1 || fifo_data !== 8'hA5) begin n_err++; $display("FAIL mid_vals: got wc=%0d empty=%b data=%h want 0/1/a5", word_count, fifo_empty, fifo_data); end
      @(negedge clk);
      rst_n = 1'b1;
      fifo_rd = 1'b0;
      req1_len = 11'd2;
      req1_valid = 1'b1;
      grant_wait(who, lat);
      req1_valid = 1'b0;
      n_cmp++; if (who !== 1 || lat !== 1) begin n_err++; $display("FAIL mid_regrant: got who=%0d lat=%0d want 1/1", who, lat); end
      handshake(0, ok);
      n_cmp++; if (ok !== 1 || word_count !== 11'd2) begin n_err++; $display("FAIL mid_wc: got ok=%0d wc=%0d want 1/2", ok, word_count); end
      do_reads(3, c0, c1);
      n_cmp++; if (c1 !== 3 || c0 !== 0) begin n_err++; $display("FAIL mid_reads: got c0=%0d c1=%0d want 0/3", c0, c1); end
      repeat (IPG + 4) @(negedge clk);
   endtask

`ifdef TX_SCHED_STATS_EN
   task automatic test_stats();
      int who, lat, ok, c0, c1;
      apply_reset();
      n_cmp++; if (frames0 !== 16'd0 || frames1 !== 16'd0) begin n_err++; $display("FAIL stats_reset: got %0d/%0d want 0/0", frames0, frames1); end
      req0_len = 11'd0;
      req1_len = 11'd0;
      for (int f = 0; f < 5; f++) begin
         if (f < 3) req0_valid = 1'b1; else req1_valid = 1'b1;
         grant_wait(who, lat);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         handshake(0, ok);
         do_reads(1, c0, c1);
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (frames0 !== 16'd3 || frames1 !== 16'd2) begin n_err++; $display("FAIL stats_count: got %0d/%0d want 3/2", frames0, frames1); end
      repeat (IPG + 4) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_len0();
      test_len2047();
      test_contention();
      test_stall();
      test_reset_mid();
`ifdef TX_SCHED_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
